// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared operation encodings and stage-count helper for pipelined_barrel_shifter.
package shifter_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_SRA  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;

    function automatic int unsigned num_stages(input int unsigned word_size,
                                               input int unsigned layers_per_stage);
        return ($clog2(word_size) + layers_per_stage - 1) / layers_per_stage;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_layer.sv
// One log-shifter layer: shifts or rotates by the fixed distance DIST when enabled.
module shift_layer
    import shifter_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned DIST      = 1
) (
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic [2:0]           i_op,
    input  logic                 i_en,
    output logic [WORD_SIZE-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                OP_SLL:  o_data = i_data << DIST;
                OP_SRL:  o_data = i_data >> DIST;
                OP_SRA:  o_data = $signed(i_data) >>> DIST;
                OP_ROL:  o_data = {i_data[WORD_SIZE-1-DIST:0], i_data[WORD_SIZE-1:WORD_SIZE-DIST]};
                OP_ROR:  o_data = {i_data[DIST-1:0], i_data[WORD_SIZE-1:DIST]};
                default: o_data = i_data;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined log shifter/rotator with valid/ready handshake and passthrough tag.
// Optional result flags (o_zero, o_shifted_out) under PIPELINED_BARREL_SHIFTER_FLAGS_EN.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WORD_SIZE        = 32,
    parameter int unsigned LAYERS_PER_STAGE = 2,
    parameter int unsigned TAG_W            = 5
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [WORD_SIZE-1:0]         i_src,
    input  logic [2:0]                   i_op,
    input  logic [$clog2(WORD_SIZE)-1:0] i_shamt,
    input  logic [TAG_W-1:0]             i_tag,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [WORD_SIZE-1:0]         o_result,
    output logic [TAG_W-1:0]             o_tag
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
    ,
    output logic                         o_zero,
    output logic                         o_shifted_out
`endif
);

    localparam int unsigned L  = $clog2(WORD_SIZE);
    localparam int unsigned NS = num_stages(WORD_SIZE, LAYERS_PER_STAGE);

    logic [NS-1:0]        r_valid;
    logic [WORD_SIZE-1:0] r_data  [NS];
    logic [2:0]           r_op    [NS];
    logic [L-1:0]         r_shamt [NS];
    logic [TAG_W-1:0]     r_tag   [NS];

    logic [NS-1:0]        w_en;
    logic [NS-1:0]        w_v_in;
    logic [WORD_SIZE-1:0] w_d_in     [NS];
    logic [2:0]           w_op_in    [NS];
    logic [L-1:0]         w_sh_in    [NS];
    logic [TAG_W-1:0]     w_tag_in   [NS];
    logic [WORD_SIZE-1:0] w_stage_out[NS];
    logic [WORD_SIZE-1:0] w_layer    [L];

    for (genvar k = 0; k < NS; k++) begin : g_stage
        localparam int unsigned LAST = ((k + 1) * LAYERS_PER_STAGE < L) ?
                                       (k + 1) * LAYERS_PER_STAGE - 1 : L - 1;
        // A stage can load unless it and every stage after it are full and the sink stalls.
        assign w_en[k]        = i_ready | ~(&r_valid[NS-1:k]);
        assign w_stage_out[k] = w_layer[LAST];
        if (k == 0) begin : g_head
            assign w_v_in[k]   = i_valid;
            assign w_d_in[k]   = i_src;
            assign w_op_in[k]  = i_op;
            assign w_sh_in[k]  = i_shamt;
            assign w_tag_in[k] = i_tag;
        end else begin : g_fwd
            assign w_v_in[k]   = r_valid[k-1];
            assign w_d_in[k]   = r_data[k-1];
            assign w_op_in[k]  = r_op[k-1];
            assign w_sh_in[k]  = r_shamt[k-1];
            assign w_tag_in[k] = r_tag[k-1];
        end
    end

    for (genvar i = 0; i < L; i++) begin : g_layer
        localparam int unsigned STG = i / LAYERS_PER_STAGE;
        logic [WORD_SIZE-1:0] w_in;
        if (i % LAYERS_PER_STAGE == 0) begin : g_first
            assign w_in = w_d_in[STG];
        end else begin : g_chain
            assign w_in = w_layer[i-1];
        end
        shift_layer #(
            .WORD_SIZE (WORD_SIZE),
            .DIST      (2 ** i)
        ) u_layer (
            .i_data (w_in),
            .i_op   (w_op_in[STG]),
            .i_en   (w_sh_in[STG][i]),
            .o_data (w_layer[i])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            for (int k = 0; k < NS; k++) begin
                r_data[k]  <= '0;
                r_op[k]    <= '0;
                r_shamt[k] <= '0;
                r_tag[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (w_en[k]) begin
                    r_valid[k] <= w_v_in[k];
                    r_data[k]  <= w_stage_out[k];
                    r_op[k]    <= w_op_in[k];
                    r_shamt[k] <= w_sh_in[k];
                    r_tag[k]   <= w_tag_in[k];
                end
            end
        end
    end

    assign o_ready  = w_en[0];
    assign o_valid  = r_valid[NS-1];
    assign o_result = r_data[NS-1];
    assign o_tag    = r_tag[NS-1];

`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
    logic          w_so_calc;
    logic [L:0]    w_lidx;
    logic [NS-1:0] r_so;
    logic          r_zero;

    // The shifted-out bit is taken from the original operand and carried down the pipe.
    always_comb begin
        w_so_calc = 1'b0;
        w_lidx    = (L + 1)'(WORD_SIZE) - {1'b0, i_shamt};
        if (i_shamt != '0) begin
            case (i_op)
                OP_SLL:         w_so_calc = i_src[w_lidx[L-1:0]];
                OP_SRL, OP_SRA: w_so_calc = i_src[i_shamt - 1'b1];
                default:        w_so_calc = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_so   <= '0;
            r_zero <= 1'b0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (w_en[k]) begin
                    r_so[k] <= (k == 0) ? w_so_calc : r_so[(k == 0) ? 0 : k - 1];
                end
            end
            if (w_en[NS-1]) begin
                r_zero <= w_v_in[NS-1] & (w_stage_out[NS-1] == '0);
            end
        end
    end

    assign o_zero        = r_zero;
    assign o_shifted_out = r_so[NS-1];
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: vector table, mid-stream reset, back-pressure and random streams.
module tb_pipelined_barrel_shifter;
    import shifter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready;
    logic        o_ready, o_valid;
    logic [31:0] i_src, o_result;
    logic [2:0]  i_op;
    logic [4:0]  i_shamt, i_tag, o_tag;
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
    logic        o_zero, o_shifted_out;
`endif

    pipelined_barrel_shifter #(
        .WORD_SIZE        (32),
        .LAYERS_PER_STAGE (2),
        .TAG_W            (5)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_src    (i_src),
        .i_op     (i_op),
        .i_shamt  (i_shamt),
        .i_tag    (i_tag),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_tag    (o_tag)
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
        ,
        .o_zero        (o_zero),
        .o_shifted_out (o_shifted_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] src;
        logic [2:0]  op;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        zero;
        logic        so;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    vec_t vecs[17];
    int   total, bad, cyc;
    bit   lat_chk, acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] s, input logic [2:0] op, input int sh);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 32; i++) begin
            case (op)
                OP_SLL:  r[i] = (i >= sh) ? s[i-sh] : 1'b0;
                OP_SRL:  r[i] = (i + sh < 32) ? s[i+sh] : 1'b0;
                OP_SRA:  r[i] = (i + sh < 32) ? s[i+sh] : s[31];
                OP_ROL:  r[i] = s[(i - sh + 32) % 32];
                OP_ROR:  r[i] = s[(i + sh) % 32];
                default: r[i] = s[i];
            endcase
        end
        return r;
    endfunction

    function automatic logic so_model(input logic [31:0] s, input logic [2:0] op, input int sh);
        if (sh == 0) return 1'b0;
        if (op == OP_SLL) return s[32-sh];
        if (op == OP_SRL || op == OP_SRA) return s[sh-1];
        return 1'b0;
    endfunction

    task automatic set_op(input logic [31:0] s, input logic [2:0] op, input logic [4:0] sh,
                          input logic [4:0] tag, input logic [31:0] exp);
        i_valid  = 1'b1;
        i_src    = s;
        i_op     = op;
        i_shamt  = sh;
        i_tag    = tag;
        cur.res  = exp;
        cur.tag  = tag;
        cur.zero = (exp == 32'h0);
        cur.so   = so_model(s, op, int'(sh));
    endtask

    // Handshakes are evaluated at the falling edge, ahead of the rising edge that commits them.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        chk("o_ready", o_ready, i_ready | (sb.size() < 3));
        if (o_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got tag=%0d result=%h required no output",
                         o_tag, o_result);
            end else begin
                e = sb[0];
                chk("result", o_result, e.res);
                chk("tag", o_tag, e.tag);
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
                chk("o_zero", o_zero, e.zero);
                chk("o_shifted_out", o_shifted_out, e.so);
`endif
                if (i_ready) begin
                    if (lat_chk) chk("latency", cyc - e.acc, 3);
                    void'(sb.pop_front());
                end
            end
        end
        acc = i_valid & o_ready;
        if (acc) begin
            e     = cur;
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [31:0] s, input logic [2:0] op, input logic [4:0] sh,
                        input logic [4:0] tag, input logic [31:0] exp);
        set_op(s, op, sh, tag, exp);
        acc = 1'b0;
        for (int g = 0; g < 20 && !acc; g++) tick();
        chk("send_accepted", acc, 1'b1);
        i_valid = 1'b0;
    endtask

    task automatic drain(input int max);
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int g = 0; g < max && sb.size() != 0; g++) tick();
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic stream(input int n, input bit rnd_ready);
        int          sent;
        logic [31:0] s;
        logic [2:0]  op;
        logic [4:0]  sh;
        sent = 0;
        s  = $urandom;
        op = 3'($urandom_range(0, 7));
        sh = 5'($urandom_range(0, 31));
        for (int g = 0; g < n * 20 && sent < n; g++) begin
            i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($urandom_range(0, 3) != 0) set_op(s, op, sh, 5'(sent), model(s, op, int'(sh)));
            else i_valid = 1'b0;
            tick();
            if (acc) begin
                sent++;
                s  = $urandom;
                op = 3'($urandom_range(0, 7));
                sh = 5'($urandom_range(0, 31));
            end
        end
        chk("stream_sent", sent, n);
        i_valid = 1'b0;
        i_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_src = '0; i_op = '0; i_shamt = '0; i_tag = '0;
        total = 0; bad = 0; cyc = 0; lat_chk = 1'b1; acc = 1'b0;
        cur = '{res: '0, tag: '0, zero: 1'b0, so: 1'b0, acc: 0};

        vecs[0]  = '{32'h8000_00F1, OP_SLL,  5'd4,  32'h0000_0F10};
        vecs[1]  = '{32'h8000_00F1, OP_SRL,  5'd4,  32'h0800_000F};
        vecs[2]  = '{32'h8000_00F1, OP_SRA,  5'd4,  32'hF800_000F};
        vecs[3]  = '{32'h8000_00F1, OP_ROL,  5'd4,  32'h0000_0F18};
        vecs[4]  = '{32'h8000_00F1, OP_ROR,  5'd4,  32'h1800_000F};
        vecs[5]  = '{32'h8000_00F1, 3'b111,  5'd4,  32'h8000_00F1};
        vecs[6]  = '{32'hDEAD_BEEF, OP_PASS, 5'd0,  32'hDEAD_BEEF};
        vecs[7]  = '{32'hDEAD_BEEF, OP_SLL,  5'd0,  32'hDEAD_BEEF};
        vecs[8]  = '{32'hDEAD_BEEF, OP_SRL,  5'd0,  32'hDEAD_BEEF};
        vecs[9]  = '{32'hDEAD_BEEF, OP_SRA,  5'd0,  32'hDEAD_BEEF};
        vecs[10] = '{32'hDEAD_BEEF, OP_ROL,  5'd0,  32'hDEAD_BEEF};
        vecs[11] = '{32'hDEAD_BEEF, OP_ROR,  5'd0,  32'hDEAD_BEEF};
        vecs[12] = '{32'h8000_0000, OP_SRA,  5'd31, 32'hFFFF_FFFF};
        vecs[13] = '{32'h0000_0001, OP_SLL,  5'd31, 32'h8000_0000};
        vecs[14] = '{32'h0000_0001, OP_ROR,  5'd31, 32'h0000_0002};
        vecs[15] = '{32'h0000_0010, OP_SRL,  5'd5,  32'h0000_0000};
        vecs[16] = '{32'h0000_0001, OP_SLL,  5'd0,  32'h0000_0001};

        #3;
        chk("reset_o_valid", o_valid, 1'b0);
        chk("reset_o_ready", o_ready, 1'b1);
        chk("reset_o_result", o_result, 32'h0);
        chk("reset_o_tag", o_tag, 5'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back table vectors, no stall: checks values, tags and latency.
        for (int i = 0; i < 17; i++) begin
            set_op(vecs[i].src, vecs[i].op, vecs[i].sh, 5'(i), vecs[i].exp);
            tick();
            chk("table_accept", acc, 1'b1);
        end
        drain(10);

        // Reset with three operations in flight; nothing may emerge afterwards.
        for (int i = 0; i < 3; i++) begin
            set_op(32'h1234_5678 + i, OP_ROL, 5'd3, 5'(20 + i),
                   model(32'h1234_5678 + i, OP_ROL, 3));
            tick();
        end
        i_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midreset_o_valid", o_valid, 1'b0);
        chk("midreset_o_ready", o_ready, 1'b1);
        chk("midreset_o_result", o_result, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 6; i++) tick();

        // Random back-pressure: ten ops tagged 0..9, then a longer random stream.
        lat_chk = 1'b0;
        stream(10, 1'b1);
        drain(50);
        stream(300, 1'b1);
        drain(50);
        lat_chk = 1'b1;
        stream(100, 1'b0);
        drain(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
